tmds_rx_align_decode: RTL and testbench
=======================================

# tmds_rx_align_decode

Receive-side TMDS channel front end for the HDMI passthrough designs. It takes the 4-bit-per-cycle deserialized stream from one IDDRX2F lane, packs it into 10-bit symbols, and finds the symbol boundary by bit-slipping until control tokens line up. It then decodes each symbol into DE, 2-bit control, and 8-bit pixel data. Three instances, one per colour lane, feed pixel-level processing that raw bit forwarding cannot do.

## Interface
Parameters:
- CTRL_RUN, 8: consecutive control tokens required to declare lock.
- SLIP_WAIT, 2048: symbols without a control token before a slip (HUNT) or lock loss (LOCKED). Must exceed one video line.

Ports:
- clk_shift_half  in  1  IDDRX2F SCLK domain (187.5 MHz at 720p); the only clock.
- rst  in  1  synchronous, active-high reset.
- nib_in  in  4  IDDRX2F Q0..Q3; nib_in[0] is the earliest received bit.
- invert  in  1  static lane polarity flip, applied to nib_in before anything else.
- sym_valid  out  1  one-cycle strobe; the outputs below carry a new symbol.
- sym  out  10  aligned raw symbol; bit 0 was received first.
- de  out  1  1 = data symbol, 0 = control token.
- ctrl  out  2  decoded control bits; holds last value while de=1.
- data  out  8  decoded pixel byte; holds last value while de=0.
- locked  out  1  alignment achieved.
- slip_count  out  4  total slips since reset; saturates at 15.

## Operation
Gearbox:
- 14-bit LSB-first buffer with a bit count `cnt` (0..13).
- Each cycle it appends 4 bits at position `cnt`.
- When the count reaches 10 or more after the append, it emits buffer[9:0] as a symbol and shifts the buffer down by 10.
- From reset, `cnt` follows 0→4→8→12(emit)→2→6→10(emit)→0: two symbols every 5 cycles.

Slip:
- A slip discards the oldest buffered bit in the same cycle as an append, so the net count change is +3.
- If that cycle would have emitted, the emission is suppressed unless the count is still 10 or more after the discard.
- A slip is never issued in the cycle that follows another slip.

FSM (states in the shared package):
- HUNT:
  - A control token increments `run` and clears `miss`. Any other symbol clears `run` and increments `miss`.
  - `run` reaching CTRL_RUN goes to LOCKED.
  - `miss` reaching SLIP_WAIT requests one slip, clears `miss`, and increments slip_count.
- LOCKED:
  - A control token clears `miss`. Any other symbol increments it.
  - `miss` reaching SLIP_WAIT goes to HUNT and clears `run`; no slip is issued on that transition.
- locked = (state == LOCKED).

Control tokens:
- 0x354 (1101010100) → 00
- 0x0AB (0010101011) → 01
- 0x154 (0101010100) → 10
- 0x2AB (1010101011) → 11

Data decode, for q = sym:
- d = q[9] ? ~q[7:0] : q[7:0]
- data[0] = d[0]
- For i in 1..7: data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Every non-token symbol decodes as data; there is no error flag.

Decoding runs in every state; consumers qualify the outputs with `locked`.

Reset:
- Outputs: all 0 (sym_valid, sym, de, ctrl, data, locked, slip_count).
- Internal: buffer=0, cnt=0, run=0, miss=0, state=HUNT.
- Reset mid-stream discards partial bits. Realignment restarts from scratch.

## Timing
- All outputs are registered.
- sym_valid, sym, de, ctrl, and data update in the cycle after the nibble that completes the symbol is sampled.
- sym_valid is never high in two consecutive cycles.
- locked rises in the same cycle as the sym_valid of the CTRL_RUN-th token, and falls with the sym_valid of the SLIP_WAIT-th miss.
- A slip takes effect on the append in the cycle after the triggering symbol's sym_valid.
- Worst-case lock from power-up: 9 slips × SLIP_WAIT symbols + CTRL_RUN.

## Structure
- Shared package `tmds_pkg` holds:
  - the four control-token constants and the token→ctrl mapping function;
  - the state enum {HUNT, LOCKED};
  - the symbol width constant (10).
- Sub-module `tmds_gearbox_4to10` holds the buffer, count, and slip logic. It exposes nib, slip, sym_valid, and sym.
- The FSM and decoder live in the top module.

## Test plan
- Reset: assert rst for 3 cycles while driving random nibbles → every output 0 and sym_valid never pulses. Deassert → sym_valid cadence is exactly 2 pulses per 5 cycles.
- Aligned lock: continuous 0x354 stream at bit offset 0, invert=0, CTRL_RUN=8 → locked rises on the 8th sym_valid, ctrl=00, de=0, slip_count=0.
- Misaligned lock: SLIP_WAIT=16, 0x0AB stream shifted by 3 bits → slip_count ≥1 before lock, locked=1 with at most 9 slips, ctrl=01, sym=0x0AB.
- Decode: once locked, inject sym 0x100 → de=1, data=0x00. Inject sym 0x2FF → data=0xFE. Then a 0x2AB token → de=0, ctrl=11, data holds 0xFE.
- Loss: once locked with SLIP_WAIT=16, send 16 consecutive data symbols → locked falls with the 16th sym_valid, no slip issued, state HUNT.
- Polarity and mid-run reset: invert=1 with bitwise-inverted tokens → same result as the aligned-lock case. Assert rst mid-stream → all outputs 0 next cycle, and relock occurs after CTRL_RUN tokens.

Source files
------------

// File: rtl/tmds_rx_align_decode_pkg.sv
// Shared TMDS receive definitions: symbol width, control tokens, FSM states
// and the per-symbol decode helpers.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;

  localparam logic [SYM_W-1:0] TOK_00 = 10'h354;
  localparam logic [SYM_W-1:0] TOK_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TOK_10 = 10'h154;
  localparam logic [SYM_W-1:0] TOK_11 = 10'h2AB;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] ctrl;
  } token_t;

  function automatic token_t token_decode(input logic [SYM_W-1:0] s);
    token_t t;
    t.hit  = 1'b1;
    t.ctrl = 2'b00;
    case (s)
      TOK_00:  t.ctrl = 2'b00;
      TOK_01:  t.ctrl = 2'b01;
      TOK_10:  t.ctrl = 2'b10;
      TOK_11:  t.ctrl = 2'b11;
      default: t.hit  = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] data_decode(input logic [SYM_W-1:0] q);
    logic [7:0] d;
    logic [7:0] r;
    d    = q[9] ? ~q[7:0] : q[7:0];
    r    = '0;
    r[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

endpackage

// File: rtl/tmds_rx_align_decode_if.sv
// Lane-side bundle: deserialized nibbles in, aligned/decoded symbols out.
interface tmds_rx_align_decode_if;
  import tmds_pkg::*;

  logic [3:0]       nib_in;
  logic             invert;
  logic             sym_valid;
  logic [SYM_W-1:0] sym;
  logic             de;
  logic [1:0]       ctrl;
  logic [7:0]       data;
  logic             locked;
  logic [3:0]       slip_count;

  modport master (
    output nib_in, invert,
    input  sym_valid, sym, de, ctrl, data, locked, slip_count
  );

  modport slave (
    input  nib_in, invert,
    output sym_valid, sym, de, ctrl, data, locked, slip_count
  );

endinterface

// File: rtl/tmds_rx_align_decode_gearbox.sv
// 4-to-10 bit gearbox with single-bit slip; emission is combinational from
// the current append so the consumer can register it on the same edge.
module tmds_gearbox_4to10
  import tmds_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       nib,
  input  logic             slip,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym
);

  logic [13:0] buffer;
  logic [3:0]  cnt;
  logic        slip_last;
  logic        slip_eff;
  logic [13:0] merged;
  logic [4:0]  level;

  always_comb begin
    slip_eff = slip & ~slip_last;
    merged   = buffer | ({10'b0, nib} << cnt);
    level    = {1'b0, cnt} + 5'd4;
    // Discarding the oldest bit happens before the emit decision.
    if (slip_eff) begin
      merged = merged >> 1;
      level  = level - 5'd1;
    end
    sym_valid = (level >= 5'd10);
    sym       = merged[SYM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer    <= '0;
      cnt       <= '0;
      slip_last <= 1'b0;
    end else begin
      slip_last <= slip_eff;
      if (sym_valid) begin
        buffer <= merged >> 10;
        cnt    <= 4'(level - 5'd10);
      end else begin
        buffer <= merged;
        cnt    <= level[3:0];
      end
    end
  end

endmodule

// File: rtl/tmds_rx_align_decode.sv
// TMDS lane front end: gearbox, token-based alignment FSM and symbol decoder.
module tmds_rx_align_decode
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN  = 8,
  parameter int unsigned SLIP_WAIT = 2048
) (
  input  logic                 clk_shift_half,
  input  logic                 rst,
  tmds_rx_align_decode_if.slave bus
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned MISS_W = $clog2(SLIP_WAIT + 1);

  state_t             state, state_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [MISS_W-1:0]  miss, miss_n;
  logic [3:0]         slips, slips_n;
  logic               slip_req, slip_req_n, slip_go;
  logic [3:0]         nib;
  logic               gb_valid;
  logic [SYM_W-1:0]   gb_sym;
  token_t             tok;

  assign nib = bus.nib_in ^ {4{bus.invert}};
  assign tok = token_decode(gb_sym);

  tmds_gearbox_4to10 u_gearbox (
    .clk       (clk_shift_half),
    .rst       (rst),
    .nib       (nib),
    .slip      (slip_go),
    .sym_valid (gb_valid),
    .sym       (gb_sym)
  );

  always_comb begin
    state_n    = state;
    run_n      = run;
    miss_n     = miss;
    slips_n    = slips;
    slip_req_n = 1'b0;
    if (gb_valid) begin
      case (state)
        HUNT: begin
          if (tok.hit) begin
            run_n  = run + RUN_W'(1);
            miss_n = '0;
            if (run_n == RUN_W'(CTRL_RUN)) state_n = LOCKED;
          end else begin
            run_n  = '0;
            miss_n = miss + MISS_W'(1);
            if (miss_n == MISS_W'(SLIP_WAIT)) begin
              slip_req_n = 1'b1;
              miss_n     = '0;
              slips_n    = (slips == 4'hF) ? slips : slips + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (tok.hit) miss_n = '0;
          else         miss_n = miss + MISS_W'(1);
          if (miss_n == MISS_W'(SLIP_WAIT)) begin
            state_n = HUNT;
            run_n   = '0;
            miss_n  = '0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // The slip is held one extra register so it lands on the append after sym_valid.
  always_ff @(posedge clk_shift_half) begin
    if (rst) begin
      state    <= HUNT;
      run      <= '0;
      miss     <= '0;
      slips    <= '0;
      slip_req <= 1'b0;
      slip_go  <= 1'b0;
    end else begin
      state    <= state_n;
      run      <= run_n;
      miss     <= miss_n;
      slips    <= slips_n;
      slip_req <= slip_req_n;
      slip_go  <= slip_req;
    end
  end

  always_ff @(posedge clk_shift_half) begin
    if (rst) begin
      bus.sym_valid <= 1'b0;
      bus.sym       <= '0;
      bus.de        <= 1'b0;
      bus.ctrl      <= '0;
      bus.data      <= '0;
    end else begin
      bus.sym_valid <= gb_valid;
      if (gb_valid) begin
        bus.sym <= gb_sym;
        bus.de  <= ~tok.hit;
        if (tok.hit) bus.ctrl <= tok.ctrl;
        else         bus.data <= data_decode(gb_sym);
      end
    end
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.slip_count = slips;

endmodule

// File: tb/tb_tmds_rx_align_decode.sv
// Directed bench for tmds_rx_align_decode: bit-serial stimulus packed into
// nibbles, with hand-derived expectations checked by immediate assertions.
module tb_tmds_rx_align_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          bq[$];
  logic [9:0]  fill = 10'h354;

  tmds_rx_align_decode_if bus ();

  tmds_rx_align_decode #(.CTRL_RUN(8), .SLIP_WAIT(16)) dut (
    .clk_shift_half (clk),
    .rst            (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
  endtask

  task automatic tick();
    logic [3:0] n;
    while (bq.size() < 4) push_sym(fill);
    for (int i = 0; i < 4; i++) n[i] = bq.pop_front();
    bus.nib_in = n;
    @(posedge clk);
    #1;
  endtask

  task automatic next_pulse(input string tag);
    int unsigned t = 0;
    do begin
      tick();
      t++;
    end while (!bus.sym_valid && t < 8);
    chk({tag, "_pulse"}, 16'(bus.sym_valid), 16'd1);
  endtask

  task automatic rst_cycle();
    rst        = 1'b1;
    bus.nib_in = 4'($urandom);
    @(posedge clk);
    #1;
    chk("rst_sym_valid",  16'(bus.sym_valid),  16'd0);
    chk("rst_sym",        16'(bus.sym),        16'd0);
    chk("rst_de",         16'(bus.de),         16'd0);
    chk("rst_ctrl",       16'(bus.ctrl),       16'd0);
    chk("rst_data",       16'(bus.data),       16'd0);
    chk("rst_locked",     16'(bus.locked),     16'd0);
    chk("rst_slip_count", 16'(bus.slip_count), 16'd0);
  endtask

  initial begin
    int unsigned k;
    logic        exp_v;
    bus.invert = 1'b0;
    bus.nib_in = '0;

    // Reset, then cadence and aligned lock on a 0x354 stream.
    for (int i = 0; i < 3; i++) rst_cycle();
    rst = 1'b0;
    bq.delete();
    fill = 10'h354;
    k = 0;
    for (int n = 1; n <= 25; n++) begin
      tick();
      exp_v = (n % 5 == 3) || (n % 5 == 0);
      chk("cadence", 16'(bus.sym_valid), 16'(exp_v));
      if (bus.sym_valid) begin
        k++;
        chk("aligned_sym", 16'(bus.sym), 16'h354);
        chk("aligned_locked", 16'(bus.locked), 16'(k >= 8));
      end
    end
    chk("aligned_ctrl",  16'(bus.ctrl),       16'd0);
    chk("aligned_de",    16'(bus.de),         16'd0);
    chk("aligned_slips", 16'(bus.slip_count), 16'd0);

    // Data decode while locked.
    push_sym(10'h100);
    push_sym(10'h2FF);
    push_sym(10'h2AB);
    next_pulse("dec_sync");
    for (int i = 0; i < 20 && bus.sym === 10'h354; i++) next_pulse("dec_sync");
    chk("dec0_sym",  16'(bus.sym),  16'h100);
    chk("dec0_de",   16'(bus.de),   16'd1);
    chk("dec0_data", 16'(bus.data), 16'h00);
    chk("dec0_ctrl", 16'(bus.ctrl), 16'd0);
    next_pulse("dec1");
    chk("dec1_sym",  16'(bus.sym),  16'h2FF);
    chk("dec1_de",   16'(bus.de),   16'd1);
    chk("dec1_data", 16'(bus.data), 16'hFE);
    next_pulse("dec2");
    chk("dec2_de",     16'(bus.de),     16'd0);
    chk("dec2_ctrl",   16'(bus.ctrl),   16'd3);
    chk("dec2_data",   16'(bus.data),   16'hFE);
    chk("dec2_locked", 16'(bus.locked), 16'd1);

    // Lock loss after 16 data symbols, then relock on tokens.
    for (int i = 0; i < 16; i++) push_sym(10'h100);
    next_pulse("loss_sync");
    for (int i = 0; i < 20 && bus.sym !== 10'h100; i++) next_pulse("loss_sync");
    for (int j = 1; j <= 16; j++) begin
      chk("loss_sym",    16'(bus.sym),    16'h100);
      chk("loss_locked", 16'(bus.locked), 16'(j < 16));
      if (j < 16) next_pulse("loss");
    end
    chk("loss_slips", 16'(bus.slip_count), 16'd0);
    for (int j = 1; j <= 8; j++) begin
      next_pulse("relock");
      chk("relock_sym",    16'(bus.sym),    16'h354);
      chk("relock_locked", 16'(bus.locked), 16'(j >= 8));
    end
    chk("relock_slips", 16'(bus.slip_count), 16'd0);

    // Mid-stream reset, then a 0x0AB stream offset by 3 bits needs 3 slips.
    rst_cycle();
    rst = 1'b0;
    bq.delete();
    bq.push_back(1'b1);
    bq.push_back(1'b0);
    bq.push_back(1'b1);
    fill = 10'h0AB;
    for (int i = 0; i < 600 && !bus.locked; i++) tick();
    chk("mis_locked", 16'(bus.locked),     16'd1);
    chk("mis_slips",  16'(bus.slip_count), 16'd3);
    chk("mis_sym",    16'(bus.sym),        16'h0AB);
    chk("mis_ctrl",   16'(bus.ctrl),       16'd1);
    chk("mis_de",     16'(bus.de),         16'd0);

    // Inverted lane carrying ~0x354 (= 0x0AB raw) must look like the aligned case.
    bus.invert = 1'b1;
    rst_cycle();
    rst = 1'b0;
    bq.delete();
    fill = 10'h0AB;
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.sym_valid) begin
        k++;
        chk("inv_sym",    16'(bus.sym),    16'h354);
        chk("inv_locked", 16'(bus.locked), 16'(k >= 8));
      end
    end
    chk("inv_pulses", 16'(k),              16'd8);
    chk("inv_ctrl",   16'(bus.ctrl),       16'd0);
    chk("inv_slips",  16'(bus.slip_count), 16'd0);

    // Reset in the middle of a symbol; relock from scratch after 8 tokens.
    tick();
    tick();
    tick();
    rst_cycle();
    rst = 1'b0;
    bq.delete();
    k = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.sym_valid) begin
        k++;
        chk("mrst_sym",    16'(bus.sym),    16'h354);
        chk("mrst_locked", 16'(bus.locked), 16'(k >= 8));
      end
    end
    chk("mrst_pulses", 16'(k), 16'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
